// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - instruction phase sequencer (fetch/decode/execute/writeback)
module cpu_seq #(
  parameter int FETCH_TMO = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_req,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic             illegal_op,
  output logic             step1,
  output logic             step2,
  output logic             step3,
  output logic             step4,
  output logic             wb_en,
  output logic             pc_inc,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // One-hot encoding keeps every output a single-bit decode of the state register.
  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    FETCH  = 6'b000010,
    DECODE = 6'b000100,
    EXEC   = 6'b001000,
    WB     = 6'b010000,
    FAULT  = 6'b100000
  } state_t;

  localparam logic [7:0]       TMO_LAST = 8'(FETCH_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic       one_shot;
  logic       one_shot_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;

  // State, mode flag, fetch wait counter and retired counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      one_shot <= 1'b0;
      wait_cnt <= 8'd0;
      retired  <= '0;
    end else begin
      state    <= state_nxt;
      one_shot <= one_shot_nxt;
      wait_cnt <= wait_nxt;
      if (state == WB) begin
        retired <= retired + CNT_ONE;
      end
    end
  end

  // Next-state logic; run is only consulted in IDLE and at the end of WB.
  always_comb begin
    state_nxt    = state;
    one_shot_nxt = one_shot;
    wait_nxt     = wait_cnt;
    unique case (state)
      IDLE: begin
        if (run || step_req) begin
          state_nxt    = FETCH;
          one_shot_nxt = !run;
          wait_nxt     = 8'd0;
        end
      end
      FETCH: begin
        if (fetch_ack) begin
          state_nxt = DECODE;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == TMO_LAST) begin
          state_nxt = FAULT;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      DECODE: begin
        state_nxt = illegal_op ? FAULT : EXEC;
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        if (run && !one_shot) begin
          state_nxt = FETCH;
          wait_nxt  = 8'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = FAULT;
      end
    endcase
  end

  // Outputs are pure decodes of the registered state, so no input reaches an output.
  assign fetch_req = state[1];
  assign step1     = state[1];
  assign step2     = state[2];
  assign step3     = state[3];
  assign step4     = state[4];
  assign wb_en     = state[4];
  assign pc_inc    = state[4];
  assign halted    = state[0];
  assign fault     = state[5];

endmodule
